memory_arbiter: RTL and testbench

- Sequential memory controller directly downstream of the datapath request stage.
- Consumes imemREN/dmemREN/dmemWEN plus addresses and store data, and arbitrates them onto one single-ported, variable-latency RAM.
- Returns ihit/dhit and load data to the request stage and datapath.
- Data accesses take priority over instruction fetch. A watchdog flags a RAM that never answers.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/memarb_watchdog.sv | 29 ++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, machine word and
// arbiter FSM state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2,
      ERR  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/memarb_watchdog.sv
// Counts consecutive enabled cycles; expired is high on the TIMEOUT-th one.
module memarb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + W'(1);
      end
   end

   // The count never passes TIMEOUT-1: expiry forces the FSM out of the access states.
   assign expired = en && !clr && (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates data and instruction requests onto one variable-latency RAM.
// Optional statistics counters are enabled with the MEMARB_STATS_EN macro.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      imemREN,
   input  word_t     imemaddr,
   output word_t     imemload,
   output logic      ihit,
   input  logic      dmemREN,
   input  logic      dmemWEN,
   input  word_t     dmemaddr,
   input  word_t     dmemstore,
   output word_t     dmemload,
   output logic      dhit,
   output word_t     ramaddr,
   output word_t     ramstore,
   output logic      ramREN,
   output logic      ramWEN,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      mem_err
`ifdef MEMARB_STATS_EN
   ,
   output logic [CNT_W-1:0] icount,
   output logic [CNT_W-1:0] dcount,
   output logic [CNT_W-1:0] stall_count
`endif
);

   arb_state_t state_reg, state_next;
   word_t      addr_reg, store_reg, imemload_reg, dmemload_reg;
   logic       write_reg, ihit_reg, dhit_reg;
   logic       accept_d, accept_i, done, in_access, wd_expired;

   assign in_access = (state_reg == DACC) || (state_reg == IACC);

   memarb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (CLK),
      .rst_n   (nRST),
      .clr     (!in_access),
      .en      (in_access && (ramstate != ACCESS)),
      .expired (wd_expired)
   );

   always_comb begin
      state_next = state_reg;
      accept_d   = 1'b0;
      accept_i   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (dmemWEN || dmemREN) begin
               state_next = DACC;
               accept_d   = 1'b1;
            end else if (imemREN) begin
               state_next = IACC;
               accept_i   = 1'b1;
            end
         end
         DACC, IACC: begin
            if (ramstate == ACCESS) begin
               state_next = IDLE;
               done       = 1'b1;
            end else if ((ramstate == ERROR) || wd_expired) begin
               state_next = ERR;
            end
         end
         ERR:     state_next = ERR;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         store_reg    <= '0;
         write_reg    <= 1'b0;
         imemload_reg <= '0;
         dmemload_reg <= '0;
         ihit_reg     <= 1'b0;
         dhit_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         ihit_reg  <= done && (state_reg == IACC);
         dhit_reg  <= done && (state_reg == DACC);
         if (accept_d) begin
            addr_reg  <= dmemaddr;
            store_reg <= dmemstore;
            write_reg <= dmemWEN;
         end else if (accept_i) begin
            addr_reg  <= imemaddr;
            write_reg <= 1'b0;
         end
         if (done && (state_reg == IACC)) begin
            imemload_reg <= ramload;
         end
         if (done && (state_reg == DACC) && !write_reg) begin
            dmemload_reg <= ramload;
         end
      end
   end

   // Strobes follow the latched request only, so they are low in IDLE and ERR.
   assign ramREN   = (state_reg == IACC) || ((state_reg == DACC) && !write_reg);
   assign ramWEN   = (state_reg == DACC) && write_reg;
   assign ramaddr  = addr_reg;
   assign ramstore = store_reg;
   assign imemload = imemload_reg;
   assign dmemload = dmemload_reg;
   assign ihit     = ihit_reg;
   assign dhit     = dhit_reg;
   assign mem_err  = (state_reg == ERR);

`ifdef MEMARB_STATS_EN
   logic [CNT_W-1:0] icount_reg, dcount_reg, stall_count_reg;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icount_reg      <= '0;
         dcount_reg      <= '0;
         stall_count_reg <= '0;
      end else begin
         if (ihit_reg && (icount_reg != '1)) begin
            icount_reg <= icount_reg + CNT_W'(1);
         end
         if (dhit_reg && (dcount_reg != '1)) begin
            dcount_reg <= dcount_reg + CNT_W'(1);
         end
         if (in_access && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
         end
      end
   end

   assign icount      = icount_reg;
   assign dcount      = dcount_reg;
   assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, collision, write priority, reset,
// watchdog and (with MEMARB_STATS_EN) statistics saturation.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      imemREN, dmemREN, dmemWEN;
   word_t     imemaddr, dmemaddr, dmemstore, ramload;
   word_t     imemload, dmemload, ramaddr, ramstore;
   logic      ihit, dhit, ramREN, ramWEN, mem_err;
   ramstate_t ramstate;
`ifdef MEMARB_STATS_EN
   logic [3:0] icount, dcount, stall_count;
`endif

   int passed = 0;
   int total  = 0;
   logic dual_hit_seen = 1'b0;

   memory_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .imemREN   (imemREN),
      .imemaddr  (imemaddr),
      .imemload  (imemload),
      .ihit      (ihit),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .dmemaddr  (dmemaddr),
      .dmemstore (dmemstore),
      .dmemload  (dmemload),
      .dhit      (dhit),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramload   (ramload),
      .ramstate  (ramstate),
      .mem_err   (mem_err)
`ifdef MEMARB_STATS_EN
      ,
      .icount      (icount),
      .dcount      (dcount),
      .stall_count (stall_count)
`endif
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (ihit && dhit) dual_hit_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
      imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE;
      tick(); tick();
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_hits", {ihit, dhit}, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_imemload", imemload, 0);
      nRST = 1'b1;
      tick();

      // Single fetch with two BUSY cycles
      imemREN = 1'b1; imemaddr = 32'h0000_0040;
      tick();
      imemREN = 1'b0; ramstate = BUSY;
      chk("fetch_ren_c2", ramREN, 1);
      chk("fetch_addr", ramaddr, 32'h0000_0040);
      chk("fetch_ihit_c2", ihit, 0);
      tick();
      chk("fetch_ren_c3", ramREN, 1);
      tick();
      chk("fetch_ren_c4", ramREN, 1);
      ramstate = ACCESS; ramload = 32'h2008_0001;
      tick();
      ramstate = FREE; ramload = '0;
      chk("fetch_ihit_c5", ihit, 1);
      chk("fetch_ren_c5", ramREN, 0);
      chk("fetch_load", imemload, 32'h2008_0001);
      tick();
      chk("fetch_ihit_c6", ihit, 0);
      $display("fetch done imemload=%h", imemload);

      // Collision: data first, then the fetch
      imemREN = 1'b1; imemaddr = 32'h0000_0044;
      dmemREN = 1'b1; dmemaddr = 32'h0000_0100;
      tick();
      chk("coll_d_ren", ramREN, 1);
      chk("coll_d_wen", ramWEN, 0);
      chk("coll_d_addr", ramaddr, 32'h0000_0100);
      ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
      tick();
      chk("coll_dhit", dhit, 1);
      chk("coll_no_ihit", ihit, 0);
      chk("coll_dload", dmemload, 32'hDEAD_BEEF);
      dmemREN = 1'b0; ramstate = FREE; ramload = '0;
      tick();
      chk("coll_i_ren", ramREN, 1);
      chk("coll_i_addr", ramaddr, 32'h0000_0044);
      chk("coll_i_nohit", {ihit, dhit}, 0);
      imemREN = 1'b0; ramstate = ACCESS; ramload = 32'h0BAD_F00D;
      tick();
      chk("coll_ihit", {ihit, dhit}, 2'b10);
      chk("coll_iload", imemload, 32'h0BAD_F00D);
      ramstate = FREE; ramload = '0;
      tick();
      $display("collision done dmemload=%h imemload=%h", dmemload, imemload);

      // Write wins over read
      dmemREN = 1'b1; dmemWEN = 1'b1; dmemstore = 32'h1234_5678; dmemaddr = 32'h0000_0200;
      tick();
      chk("wr_wen", ramWEN, 1);
      chk("wr_ren", ramREN, 0);
      chk("wr_store", ramstore, 32'h1234_5678);
      chk("wr_addr", ramaddr, 32'h0000_0200);
      ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
      tick();
      chk("wr_dhit", dhit, 1);
      chk("wr_dload_kept", dmemload, 32'hDEAD_BEEF);
      dmemREN = 1'b0; dmemWEN = 1'b0; ramstate = FREE; ramload = '0;
      tick();
      $display("write done ramstore=%h", ramstore);

      // Reset in the middle of a data write
      dmemWEN = 1'b1; dmemaddr = 32'h0000_0300; dmemstore = 32'h0000_00AA;
      tick();
      chk("rmid_wen_before", ramWEN, 1);
      nRST = 1'b0;
      #1;
      chk("rmid_wen", ramWEN, 0);
      chk("rmid_ren", ramREN, 0);
      chk("rmid_ramaddr", ramaddr, 0);
      chk("rmid_ramstore", ramstore, 0);
      chk("rmid_loads", {imemload, dmemload} == '0, 1);
      dmemWEN = 1'b0; ramstate = ACCESS;
      tick();
      nRST = 1'b1;
      tick();
      chk("rmid_no_dhit1", dhit, 0);
      chk("rmid_idle_wen", ramWEN, 0);
      tick();
      chk("rmid_no_dhit2", dhit, 0);
      ramstate = FREE;
      $display("reset mid-access done");

      // Watchdog timeout with RAM stuck BUSY
      imemREN = 1'b1; imemaddr = 32'h0000_0080;
      tick();
      imemREN = 1'b0; ramstate = BUSY;
      for (int i = 0; i < 7; i++) tick();
      chk("to_err_pre", mem_err, 0);
      chk("to_ren_pre", ramREN, 1);
      tick();
      chk("to_err", mem_err, 1);
      chk("to_strobes", {ramREN, ramWEN}, 0);
      chk("to_nohit", {ihit, dhit}, 0);
      imemREN = 1'b1; dmemREN = 1'b1; ramstate = ACCESS;
      tick(); tick();
      chk("to_sticky", mem_err, 1);
      chk("to_sticky_nohit", {ihit, dhit}, 0);
      chk("to_sticky_strobes", {ramREN, ramWEN}, 0);
      imemREN = 1'b0; dmemREN = 1'b0; ramstate = FREE;
      nRST = 1'b0;
      tick();
      chk("to_rst_clear", mem_err, 0);
      nRST = 1'b1;
      tick();
      $display("timeout done");

      // Single ERROR response
      dmemREN = 1'b1; dmemaddr = 32'h0000_0010;
      tick();
      dmemREN = 1'b0; ramstate = ERROR;
      tick();
      ramstate = FREE;
      chk("rerr_err", mem_err, 1);
      chk("rerr_strobes", {ramREN, ramWEN}, 0);
      tick();
      chk("rerr_sticky", mem_err, 1);
      chk("rerr_nohit", {ihit, dhit}, 0);
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      tick();
      $display("ram error done");

`ifdef MEMARB_STATS_EN
      chk("st_icount0", icount, 0);
      imemREN = 1'b1; ramstate = ACCESS; ramload = 32'h0000_0013;
      for (int i = 0; i < 40; i++) tick();
      imemREN = 1'b0; ramstate = FREE;
      tick();
      chk("st_icount", icount, 15);
      chk("st_dcount", dcount, 0);
      chk("st_stall", stall_count, 15);
      $display("stats icount=%0d dcount=%0d stall=%0d", icount, dcount, stall_count);
`endif

      chk("no_dual_hit", dual_hit_seen, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
